// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: decode, alignment check, lane steering, bus issue and in-order load return.
// Define LSU_UNALIGNED_EN to build the LWL/LWR/SWL/SWR datapath; otherwise those ops are dropped.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  input  logic              flush,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [3:0]        bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [31:0]       bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              exc_valid,
  output logic              exc_load,
  output logic [ADDR_W-1:0] exc_badvaddr,
  output logic              busy
);

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,  OP_LBU = 4'd1,  OP_LH  = 4'd2,  OP_LHU = 4'd3,
    OP_LW  = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6,
    OP_SB  = 4'd8,  OP_SH  = 4'd9,  OP_SW  = 4'd10, OP_SWL = 4'd11, OP_SWR = 4'd12
  } op_e;

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(OUTSTANDING);

  // Request decode
  logic [1:0]  off;
  logic        dec_known, dec_load, dec_fault;
  logic [3:0]  dec_we;
  logic [31:0] dec_wdata;
  logic        accept, issue, push, pop, raise_exc;

  // Registered outputs
  logic              bus_req_valid_q, bus_req_valid_d;
  logic [3:0]        bus_req_we_q, bus_req_we_d;
  logic [ADDR_W-1:0] bus_req_addr_q, bus_req_addr_d;
  logic [31:0]       bus_req_wdata_q, bus_req_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              exc_valid_q, exc_valid_d;
  logic              exc_load_q, exc_load_d;
  logic [ADDR_W-1:0] exc_badvaddr_q, exc_badvaddr_d;

  // Load tracking FIFO
  logic [3:0]       fifo_op_q   [OUTSTANDING];
  logic [3:0]       fifo_op_d   [OUTSTANDING];
  logic [1:0]       fifo_off_q  [OUTSTANDING];
  logic [1:0]       fifo_off_d  [OUTSTANDING];
  logic             fifo_disc_q [OUTSTANDING];
  logic             fifo_disc_d [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef LSU_UNALIGNED_EN
  logic [31:0]      fifo_rt_q   [OUTSTANDING];
  logic [31:0]      fifo_rt_d   [OUTSTANDING];
`else
  logic             unused_rt_old;
  assign unused_rt_old = ^req_rt_old;
`endif

  // Load result formatting
  logic [3:0]  head_op;
  logic [1:0]  head_off;
  logic [31:0] rd_shifted, ld_result;

  assign off = req_addr[1:0];

  always_comb begin
    dec_known = 1'b1;
    dec_load  = 1'b0;
    dec_fault = 1'b0;
    dec_we    = '0;
    dec_wdata = '0;
    case (req_op)
      OP_LB, OP_LBU:  dec_load = 1'b1;
      OP_LH, OP_LHU: begin
        dec_load  = 1'b1;
        dec_fault = off[0];
      end
      OP_LW: begin
        dec_load  = 1'b1;
        dec_fault = (off != 2'd0);
      end
`ifdef LSU_UNALIGNED_EN
      OP_LWL, OP_LWR: dec_load = 1'b1;
      OP_SWL: begin
        dec_we    = 4'b1111 >> (~off);
        dec_wdata = req_wdata >> {~off, 3'b000};
      end
      OP_SWR: begin
        dec_we    = 4'b1111 << off;
        dec_wdata = req_wdata << {off, 3'b000};
      end
`endif
      OP_SB: begin
        dec_we    = 4'b0001 << off;
        dec_wdata = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        dec_fault = off[0];
        dec_we    = 4'b0011 << off;
        dec_wdata = {2{req_wdata[15:0]}};
      end
      OP_SW: begin
        dec_fault = (off != 2'd0);
        dec_we    = 4'b1111;
        dec_wdata = req_wdata;
      end
      default: dec_known = 1'b0;
    endcase
  end

  assign req_ready = !reset && !flush && (!bus_req_valid_q || bus_req_ready)
                     && ((cnt_q < DEPTH) || bus_rsp_valid);
  assign accept    = req_valid && req_ready;
  assign issue     = accept && dec_known && !dec_fault;
  assign push      = issue && dec_load;
  assign raise_exc = accept && dec_known && dec_fault;
  // Responses with nothing outstanding are protocol errors and are dropped here.
  assign pop       = bus_rsp_valid && (cnt_q != '0);

  always_comb begin
    head_op    = fifo_op_q[rd_ptr_q];
    head_off   = fifo_off_q[rd_ptr_q];
    rd_shifted = bus_rsp_rdata >> {head_off, 3'b000};
    case (head_op)
      OP_LB:   ld_result = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      OP_LBU:  ld_result = {24'd0, rd_shifted[7:0]};
      OP_LH:   ld_result = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      OP_LHU:  ld_result = {16'd0, rd_shifted[15:0]};
`ifdef LSU_UNALIGNED_EN
      OP_LWL:  ld_result = (bus_rsp_rdata << {~head_off, 3'b000})
                         | (fifo_rt_q[rd_ptr_q] & ~(32'hFFFF_FFFF << {~head_off, 3'b000}));
      OP_LWR:  ld_result = rd_shifted
                         | (fifo_rt_q[rd_ptr_q] & ~(32'hFFFF_FFFF >> {head_off, 3'b000}));
`endif
      default: ld_result = bus_rsp_rdata;
    endcase
  end

  always_comb begin
    bus_req_valid_d = bus_req_valid_q;
    bus_req_we_d    = bus_req_we_q;
    bus_req_addr_d  = bus_req_addr_q;
    bus_req_wdata_d = bus_req_wdata_q;
    if (issue) begin
      bus_req_valid_d = 1'b1;
      bus_req_we_d    = dec_we;
      bus_req_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
      bus_req_wdata_d = dec_wdata;
    end else if (bus_req_valid_q && bus_req_ready) begin
      bus_req_valid_d = 1'b0;
    end

    exc_valid_d    = raise_exc;
    exc_load_d     = raise_exc ? dec_load : exc_load_q;
    exc_badvaddr_d = raise_exc ? req_addr : exc_badvaddr_q;

    // A load completing in the flush cycle is also discarded.
    rsp_valid_d = pop && !fifo_disc_q[rd_ptr_q] && !flush;
    rsp_data_d  = pop ? ld_result : rsp_data_q;

    fifo_op_d   = fifo_op_q;
    fifo_off_d  = fifo_off_q;
    fifo_disc_d = fifo_disc_q;
`ifdef LSU_UNALIGNED_EN
    fifo_rt_d   = fifo_rt_q;
`endif
    if (flush) begin
      for (int unsigned i = 0; i < OUTSTANDING; i++) fifo_disc_d[i] = 1'b1;
    end
    if (push) begin
      fifo_op_d[wr_ptr_q]   = req_op;
      fifo_off_d[wr_ptr_q]  = off;
      fifo_disc_d[wr_ptr_q] = flush;
`ifdef LSU_UNALIGNED_EN
      fifo_rt_d[wr_ptr_q]   = req_rt_old;
`endif
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req_valid_q <= 1'b0;
      bus_req_we_q    <= '0;
      bus_req_addr_q  <= '0;
      bus_req_wdata_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      exc_valid_q     <= 1'b0;
      exc_load_q      <= 1'b0;
      exc_badvaddr_q  <= '0;
      fifo_op_q       <= '{default: '0};
      fifo_off_q      <= '{default: '0};
      fifo_disc_q     <= '{default: '0};
`ifdef LSU_UNALIGNED_EN
      fifo_rt_q       <= '{default: '0};
`endif
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
    end else begin
      bus_req_valid_q <= bus_req_valid_d;
      bus_req_we_q    <= bus_req_we_d;
      bus_req_addr_q  <= bus_req_addr_d;
      bus_req_wdata_q <= bus_req_wdata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      exc_valid_q     <= exc_valid_d;
      exc_load_q      <= exc_load_d;
      exc_badvaddr_q  <= exc_badvaddr_d;
      fifo_op_q       <= fifo_op_d;
      fifo_off_q      <= fifo_off_d;
      fifo_disc_q     <= fifo_disc_d;
`ifdef LSU_UNALIGNED_EN
      fifo_rt_q       <= fifo_rt_d;
`endif
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
    end
  end

  assign bus_req_valid = bus_req_valid_q;
  assign bus_req_we    = bus_req_we_q;
  assign bus_req_addr  = bus_req_addr_q;
  assign bus_req_wdata = bus_req_wdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign exc_valid     = exc_valid_q;
  assign exc_load      = exc_load_q;
  assign exc_badvaddr  = exc_badvaddr_q;
  assign busy          = bus_req_valid_q || (cnt_q != '0);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default and LSU_UNALIGNED_EN builds).
module tb_mem_access_unit;

  localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4;
  localparam logic [3:0] LWL = 4'd5, LWR = 4'd6, SB = 4'd8, SH = 4'd9, SW = 4'd10, SWL = 4'd11;

  logic        clk;
  logic        reset, req_valid, req_ready, flush;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt_old;
  logic        bus_req_valid, bus_req_ready, bus_rsp_valid;
  logic [3:0]  bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
  logic        rsp_valid, exc_valid, exc_load, busy;
  logic [31:0] rsp_data, exc_badvaddr;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.ADDR_W(32), .OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .flush(flush), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .exc_valid(exc_valid), .exc_load(exc_load),
    .exc_badvaddr(exc_badvaddr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rt);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_op = 4'd0; req_addr = '0; req_wdata = '0; req_rt_old = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    idle_req();
    cyc(); cyc();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_req_valid: got %b expected 0", bus_req_valid); end
    checks++; if ({bus_req_we, bus_req_addr, bus_req_wdata} !== 68'd0) begin errors++; $display("FAIL reset_bus_fields: got %h expected 0", {bus_req_we, bus_req_addr, bus_req_wdata}); end
    checks++; if ({rsp_valid, rsp_data} !== 33'd0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_data}); end
    checks++; if ({exc_valid, exc_load, exc_badvaddr} !== 34'd0) begin errors++; $display("FAIL reset_exc: got %h expected 0", {exc_valid, exc_load, exc_badvaddr}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_store();
    bus_req_ready = 1'b1;
    set_req(SW, 32'h100, 32'hDEADBEEF, '0);
    cyc(); idle_req();
    checks++; if (bus_req_valid !== 1'b1) begin errors++; $display("FAIL sw_valid: got %b expected 1", bus_req_valid); end
    checks++; if (bus_req_we !== 4'b1111) begin errors++; $display("FAIL sw_we: got %b expected 1111", bus_req_we); end
    checks++; if (bus_req_addr !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h expected 00000100", bus_req_addr); end
    checks++; if (bus_req_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", bus_req_wdata); end
    cyc();
    checks++; if ({bus_req_valid, rsp_valid, busy} !== 3'b000) begin errors++; $display("FAIL sw_done: got %b expected 000", {bus_req_valid, rsp_valid, busy}); end
    set_req(SB, 32'h101, 32'h000000AB, '0);
    cyc();
    checks++; if ({bus_req_we, bus_req_addr, bus_req_wdata} !== {4'b0010, 32'h100, 32'hABABABAB}) begin errors++; $display("FAIL sb_fields: got %b %h %h expected 0010 00000100 abababab", bus_req_we, bus_req_addr, bus_req_wdata); end
    set_req(SH, 32'h102, 32'h00001234, '0);
    cyc(); idle_req();
    checks++; if ({bus_req_valid, bus_req_we, bus_req_wdata} !== {1'b1, 4'b1100, 32'h12341234}) begin errors++; $display("FAIL sh_fields: got %b %b %h expected 1 1100 12341234", bus_req_valid, bus_req_we, bus_req_wdata); end
    cyc();
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL sh_drop: got %b expected 0", bus_req_valid); end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, rt, rdata, exp;
  } ld_t;

  task automatic test_loads();
    ld_t v[$];
    v.push_back('{op: LB,  addr: 32'h103, rt: '0, rdata: 32'h80112233, exp: 32'hFFFFFF80});
    v.push_back('{op: LBU, addr: 32'h103, rt: '0, rdata: 32'h80112233, exp: 32'h00000080});
    v.push_back('{op: LH,  addr: 32'h102, rt: '0, rdata: 32'h80112233, exp: 32'hFFFF8011});
    v.push_back('{op: LHU, addr: 32'h102, rt: '0, rdata: 32'h80112233, exp: 32'h00008011});
    v.push_back('{op: LB,  addr: 32'h101, rt: '0, rdata: 32'h80112233, exp: 32'h00000022});
    v.push_back('{op: LH,  addr: 32'h100, rt: '0, rdata: 32'h8011A233, exp: 32'hFFFFA233});
    v.push_back('{op: LW,  addr: 32'h104, rt: '0, rdata: 32'h80112233, exp: 32'h80112233});
`ifdef LSU_UNALIGNED_EN
    v.push_back('{op: LWL, addr: 32'h101, rt: 32'hAABBCCDD, rdata: 32'h11223344, exp: 32'h3344CCDD});
    v.push_back('{op: LWR, addr: 32'h101, rt: 32'hAABBCCDD, rdata: 32'h11223344, exp: 32'hAA112233});
`endif
    bus_req_ready = 1'b1;
    foreach (v[i]) begin
      set_req(v[i].op, v[i].addr, 32'hFFFFFFFF, v[i].rt);
      cyc(); idle_req();
      checks++; if ({bus_req_valid, bus_req_we, bus_req_addr} !== {1'b1, 4'b0000, v[i].addr & 32'hFFFFFFFC}) begin errors++; $display("FAIL load[%0d]_bus: got %b %b %h expected 1 0000 %h", i, bus_req_valid, bus_req_we, bus_req_addr, v[i].addr & 32'hFFFFFFFC); end
      cyc();
      bus_rsp_valid = 1'b1; bus_rsp_rdata = v[i].rdata;
      cyc();
      bus_rsp_valid = 1'b0;
      checks++; if ({rsp_valid, rsp_data} !== {1'b1, v[i].exp}) begin errors++; $display("FAIL load[%0d]_rsp: got %b %h expected 1 %h", i, rsp_valid, rsp_data, v[i].exp); end
      cyc();
      checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL load[%0d]_pulse: got %b expected 00", i, {rsp_valid, busy}); end
    end
  endtask

  task automatic test_exceptions();
    bus_req_ready = 1'b1;
    set_req(LW, 32'h102, '0, '0);
    cyc(); idle_req();
    checks++; if ({exc_valid, exc_load, exc_badvaddr} !== {2'b11, 32'h102}) begin errors++; $display("FAIL lw_exc: got %b %b %h expected 1 1 00000102", exc_valid, exc_load, exc_badvaddr); end
    checks++; if ({bus_req_valid, busy} !== 2'b00) begin errors++; $display("FAIL lw_exc_nobus: got %b expected 00", {bus_req_valid, busy}); end
    cyc();
    checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL lw_exc_pulse: got %b expected 0", exc_valid); end
    set_req(SH, 32'h101, '0, '0);
    cyc(); idle_req();
    checks++; if ({exc_valid, exc_load, exc_badvaddr, bus_req_valid} !== {2'b10, 32'h101, 1'b0}) begin errors++; $display("FAIL sh_exc: got %b %b %h %b expected 1 0 00000101 0", exc_valid, exc_load, exc_badvaddr, bus_req_valid); end
    set_req(LHU, 32'h203, '0, '0);
    cyc(); idle_req();
    checks++; if ({exc_valid, exc_load, exc_badvaddr} !== {2'b11, 32'h203}) begin errors++; $display("FAIL lhu_exc: got %b %b %h expected 1 1 00000203", exc_valid, exc_load, exc_badvaddr); end
    set_req(SW, 32'h302, '0, '0);
    cyc(); idle_req();
    checks++; if ({exc_valid, exc_load, exc_badvaddr, busy} !== {2'b10, 32'h302, 1'b0}) begin errors++; $display("FAIL sw_exc: got %b %b %h %b expected 1 0 00000302 0", exc_valid, exc_load, exc_badvaddr, busy); end
    cyc();
  endtask

  task automatic test_undefined();
    logic [3:0] ops [$];
    ops.push_back(4'd7);
    ops.push_back(4'd15);
`ifndef LSU_UNALIGNED_EN
    ops.push_back(LWL);
    ops.push_back(SWL);
`endif
    bus_req_ready = 1'b1;
    foreach (ops[i]) begin
      set_req(ops[i], 32'h100, 32'h12345678, '0);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL undef[%0d]_ready: got %b expected 1", i, req_ready); end
      cyc(); idle_req();
      checks++; if ({bus_req_valid, exc_valid, busy, rsp_valid} !== 4'b0000) begin errors++; $display("FAIL undef[%0d]_dropped: got %b expected 0000", i, {bus_req_valid, exc_valid, busy, rsp_valid}); end
    end
  endtask

  task automatic test_back_to_back();
    bus_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(LW, 32'h200 + 32'(4 * i), '0, '0);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d]_ready: got %b expected 1", i, req_ready); end
      cyc();
      checks++; if ({bus_req_valid, bus_req_addr} !== {1'b1, 32'h200 + 32'(4 * i)}) begin errors++; $display("FAIL b2b[%0d]_addr: got %b %h expected 1 %h", i, bus_req_valid, bus_req_addr, 32'h200 + 32'(4 * i)); end
    end
    idle_req();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", req_ready); end
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1000;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL pop_frees_slot: got %b expected 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      bus_rsp_rdata = 32'h1000 + 32'(i);
      cyc();
      checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h1000 + 32'(i)}) begin errors++; $display("FAIL b2b_rsp[%0d]: got %b %h expected 1 %h", i, rsp_valid, rsp_data, 32'h1000 + 32'(i)); end
    end
    bus_rsp_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
    cyc();
  endtask

  task automatic test_flush();
    bus_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(LB, 32'h500 + 32'(i), '0, '0);
      cyc();
    end
    idle_req();
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", req_ready); end
    cyc();
    flush = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b expected 1", busy); end
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h55667788;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp[%0d]: got %b expected 0", i, rsp_valid); end
    end
    bus_rsp_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_drain_busy: got %b expected 0", busy); end
    cyc();
  endtask

  task automatic test_stall();
    bus_req_ready = 1'b0;
    set_req(SW, 32'h300, 32'hCAFEF00D, '0);
    cyc();
    set_req(SB, 32'h304, 32'h00000011, '0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall[%0d]_ready: got %b expected 0", i, req_ready); end
      checks++; if ({bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata} !== {1'b1, 4'b1111, 32'h300, 32'hCAFEF00D}) begin errors++; $display("FAIL stall[%0d]_hold: got %b %b %h %h expected 1 1111 00000300 cafef00d", i, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata); end
      cyc();
    end
    idle_req();
    bus_req_ready = 1'b1;
    cyc();
    checks++; if ({bus_req_valid, busy, rsp_valid} !== 3'b000) begin errors++; $display("FAIL stall_release: got %b expected 000", {bus_req_valid, busy, rsp_valid}); end
  endtask

  task automatic test_reset_mid();
    bus_req_ready = 1'b0;
    set_req(LW, 32'h400, '0, '0);
    cyc(); idle_req();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b expected 1", busy); end
    reset = 1'b1;
    cyc();
    checks++; if ({bus_req_valid, busy, rsp_valid, exc_valid} !== 4'b0000) begin errors++; $display("FAIL midreset_clear: got %b expected 0000", {bus_req_valid, busy, rsp_valid, exc_valid}); end
    reset = 1'b0;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFFFFFF;
    cyc();
    bus_rsp_valid = 1'b0;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL empty_rsp_ignored: got %b expected 00", {rsp_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_loads();
    test_exceptions();
    test_undefined();
    test_back_to_back();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
